bin_morph_3x3: RTL and testbench
================================

Name: bin_morph_3x3

Overview:
- Consumer of the 3x3 1-bit window stream: takes matrix_frame_vsync/href/clken and matrix_p11..p33, and produces a filtered 1-bit pixel stream on post_frame_* for the next stage of the multi-target detection pipeline.
- Performs a runtime-selectable binary morphology operation: pass, 3x3 erosion, 3x3 dilation or cross erosion.
- Optionally forces frame-border pixels to 0.
- Reports the per-frame foreground pixel count.

Parameters:
IMG_HDISP, 10'd640, active pixels per line (clken pulses per href).
IMG_VDISP, 10'd480, active lines per frame.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
sys_rst_n  input  1  asynchronous reset, active low.
matrix_frame_vsync  input  1  frame sync from the window generator; a rising edge marks frame start.
matrix_frame_href  input  1  line valid.
matrix_frame_clken  input  1  pixel strobe; window valid when href and clken are both 1.
matrix_p11..matrix_p33  input  1 each  3x3 window; p22 is the centre, p1x is the oldest row, px1 is the oldest column.
mode  input  2  00 pass p22, 01 erode 3x3, 10 dilate 3x3, 11 cross erode.
border_en  input  1  1 = force border pixels to 0.
post_frame_vsync  output  1  vsync delayed 2 cycles.
post_frame_href  output  1  href delayed 2 cycles.
post_frame_clken  output  1  clken delayed 2 cycles.
post_img_Bit  output  1  filtered pixel.
fg_count  output  19  foreground pixels counted in the last completed frame.
fg_count_valid  output  1  one-cycle pulse when fg_count updates.

Behaviour:
- Reset (async, sys_rst_n=0):
  - All outputs 0, including fg_count.
  - Delay shift registers, column/row counters, accumulator, mode_r and frame_seen are cleared.
- Sync path:
  - post_frame_vsync/href/clken = input vsync/href/clken delayed by exactly 2 cycles through 2-bit shift registers, updated every cycle.
- Data path, 2 stages. Both stages advance only on cycles where the corresponding delayed clken is 1 and the delayed href is 1.
  - When the delayed href is 1 and the delayed clken is 0, the stage holds its value.
  - When the delayed href is 0, the stage clears to 0.
  - Stage 1 registers, per row r in {1,2,3}: and_r = &{pr1,pr2,pr3}, or_r = |{pr1,pr2,pr3}. It also registers p12, p21, p22, p23, p32, the border flag and mode_r.
  - Stage 2 computes post_img_Bit:
    - 00 -> p22
    - 01 -> and_1&and_2&and_3
    - 10 -> or_1|or_2|or_3
    - 11 -> p12&p21&p22&p23&p32
    - The result is then ANDed with ~(border & border_en).
  - Latency from input window to post_img_Bit is 2 cycles, aligned with post_frame_clken.
- mode_r:
  - Loaded from mode on the vsync rising edge (input side).
  - Mode changes mid-frame take effect at the next frame.
- Counters (input side):
  - col: 10 bits, cleared while href=0, incremented on each href&clken, saturating at IMG_HDISP-1.
  - row: 10 bits, cleared on the vsync rising edge, incremented on each href falling edge, saturating at IMG_VDISP-1.
  - border = (col==0) | (col>=IMG_HDISP-1) | (row==0) | (row>=IMG_VDISP-1), evaluated on the same cycle as the window it tags.
- Foreground accumulator:
  - 19 bits; adds 1 on each output cycle where post_frame_href&post_frame_clken&post_img_Bit=1.
  - Saturates at 19'h7FFFF.
- Frame boundary, on the rising edge of post_frame_vsync:
  - If frame_seen=1: fg_count <= accumulator and fg_count_valid pulses for 1 cycle.
  - In all cases: accumulator <= 0 and frame_seen <= 1.
  - The first frame edge after reset therefore produces no pulse.
  - If an increment and the frame edge occur in the same cycle, the increment is dropped; a pixel cannot occur there in a legal stream.
- Reset mid-frame: everything clears immediately; the partial frame is never reported.

Test Plan:
- Reset mid-stream: assert sys_rst_n=0 during an active line -> every output reads 0 in the same cycle (async), and it stays 0 until the next vsync after release.
- Pass mode, border_en=0, all-ones 8x4 frame (IMG_HDISP=8, IMG_VDISP=4) -> post_img_Bit=1 for all 32 pixels, each 2 cycles after its input clken; fg_count=32 with a single fg_count_valid pulse at the next vsync edge.
- Same frame with border_en=1 -> only interior 6x2 pixels are 1; fg_count=12.
- Erode with p22=1 and exactly one of the other 8 pixels 0 -> output 0. Dilate with only p11=1 -> output 1. Cross erode with only p11=0 and the rest 1 -> output 1.
- clken gaps: clken toggling 1,0,0,1 within href -> output holds its value during the gaps; post_frame_clken pattern equals the input pattern delayed by 2.
- mode changed from 00 to 10 mid-frame -> the remainder of the frame still uses pass; dilation applies from the next frame. The first vsync after reset gives no fg_count_valid pulse.

Source files
------------

// File: rtl/bin_morph_3x3_if.sv
// Window stream in from the 3x3 generator and filtered 1-bit stream out.
// The master drives the window and observes the result; the slave is the filter.
interface bin_morph_3x3_if;
    logic matrix_frame_vsync;
    logic matrix_frame_href;
    logic matrix_frame_clken;
    logic matrix_p11, matrix_p12, matrix_p13;
    logic matrix_p21, matrix_p22, matrix_p23;
    logic matrix_p31, matrix_p32, matrix_p33;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_Bit;

    modport master (
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
    );

    modport slave (
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
    );
endinterface

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 morphology (pass/erode/dilate/cross-erode) with border masking and per-frame foreground count.
// Latency 2 cycles, aligned with post_frame_clken; no backpressure, the stream advances on clken.
module bin_morph_3x3 #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    bin_morph_3x3_if.slave   win,
    input  logic [1:0]       mode,
    input  logic             border_en,
    output logic [18:0]      fg_count,
    output logic             fg_count_valid
);

    logic [1:0]  vsync_d, href_d, clken_d;
    logic        post_vsync_q;
    logic [9:0]  col, row;
    logic [1:0]  mode_r;
    logic        vs_rise, href_fall, border_in;
    logic [2:0]  row1, row2, row3;

    logic [2:0]  s1_and, s1_or;
    logic [4:0]  s1_cross;
    logic        s1_border;
    logic [1:0]  s1_mode;
    logic        filt_bit, post_bit;

    logic [18:0] acc;
    logic        frame_seen, post_vs_rise, pix_fg;

    assign vs_rise   = win.matrix_frame_vsync & ~vsync_d[0];
    assign href_fall = ~win.matrix_frame_href & href_d[0];

    assign win.post_frame_vsync = vsync_d[1];
    assign win.post_frame_href  = href_d[1];
    assign win.post_frame_clken = clken_d[1];
    assign win.post_img_Bit     = post_bit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_d      <= 2'b00;
            href_d       <= 2'b00;
            clken_d      <= 2'b00;
            post_vsync_q <= 1'b0;
        end else begin
            vsync_d      <= {vsync_d[0], win.matrix_frame_vsync};
            href_d       <= {href_d[0],  win.matrix_frame_href};
            clken_d      <= {clken_d[0], win.matrix_frame_clken};
            post_vsync_q <= vsync_d[1];
        end
    end

    // Position of the window currently on the inputs; both counters saturate.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col    <= 10'd0;
            row    <= 10'd0;
            mode_r <= 2'b00;
        end else begin
            if (!win.matrix_frame_href)
                col <= 10'd0;
            else if (win.matrix_frame_clken && (col < IMG_HDISP - 10'd1))
                col <= col + 10'd1;

            if (vs_rise)
                row <= 10'd0;
            else if (href_fall && (row < IMG_VDISP - 10'd1))
                row <= row + 10'd1;

            if (vs_rise)
                mode_r <= mode;
        end
    end

    assign border_in = (col == 10'd0) || (col >= IMG_HDISP - 10'd1) ||
                       (row == 10'd0) || (row >= IMG_VDISP - 10'd1);

    assign row1 = {win.matrix_p11, win.matrix_p12, win.matrix_p13};
    assign row2 = {win.matrix_p21, win.matrix_p22, win.matrix_p23};
    assign row3 = {win.matrix_p31, win.matrix_p32, win.matrix_p33};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_and    <= 3'b000;
            s1_or     <= 3'b000;
            s1_cross  <= 5'b00000;
            s1_border <= 1'b0;
            s1_mode   <= 2'b00;
        end else if (!win.matrix_frame_href) begin
            s1_and    <= 3'b000;
            s1_or     <= 3'b000;
            s1_cross  <= 5'b00000;
            s1_border <= 1'b0;
            s1_mode   <= 2'b00;
        end else if (win.matrix_frame_clken) begin
            s1_and    <= {&row3, &row2, &row1};
            s1_or     <= {|row3, |row2, |row1};
            s1_cross  <= {win.matrix_p12, win.matrix_p21, win.matrix_p22,
                          win.matrix_p23, win.matrix_p32};
            s1_border <= border_in;
            s1_mode   <= mode_r;
        end
    end

    // s1_cross[2] is the centre pixel p22.
    always_comb begin
        filt_bit = 1'b0;
        case (s1_mode)
            2'b00:   filt_bit = s1_cross[2];
            2'b01:   filt_bit = &s1_and;
            2'b10:   filt_bit = |s1_or;
            default: filt_bit = &s1_cross;
        endcase
        filt_bit = filt_bit & ~(s1_border & border_en);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            post_bit <= 1'b0;
        else if (!href_d[0])
            post_bit <= 1'b0;
        else if (clken_d[0])
            post_bit <= filt_bit;
    end

    assign post_vs_rise = vsync_d[1] & ~post_vsync_q;
    assign pix_fg       = href_d[1] & clken_d[1] & post_bit;

    // The first frame edge after reset only arms the counter; a partial frame is never reported.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc            <= 19'd0;
            frame_seen     <= 1'b0;
            fg_count       <= 19'd0;
            fg_count_valid <= 1'b0;
        end else begin
            fg_count_valid <= 1'b0;
            if (post_vs_rise) begin
                if (frame_seen) begin
                    fg_count       <= acc;
                    fg_count_valid <= 1'b1;
                end
                acc        <= 19'd0;
                frame_seen <= 1'b1;
            end else if (pix_fg && (acc != 19'h7FFFF)) begin
                acc <= acc + 19'd1;
            end
        end
    end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Random window frames checked cycle by cycle against a per-pixel behavioural model,
// plus literal frame counts for all-ones frames.
module tb_bin_morph_3x3;

    localparam logic [9:0] H = 10'd8;
    localparam logic [9:0] V = 10'd4;
    localparam int HI = 8;
    localparam int VI = 4;
    localparam int M  = 255;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        border_en = 1'b0;
    logic [18:0] fg_count;
    logic        fg_count_valid;

    bin_morph_3x3_if bus();

    bin_morph_3x3 #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .win            (bus),
        .mode           (mode),
        .border_en      (border_en),
        .fg_count       (fg_count),
        .fg_count_valid (fg_count_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cur_x = 0;
    int cur_y = 0;
    int cyc   = 0;
    int pulse_cnt = 0;

    bit h_vs[M+1], h_hr[M+1], h_ck[M+1], h_bit[M+1], h_pulse[M+1];
    int h_cnt[M+1];

    bit         m_seen = 1'b0, m_prev_vs = 1'b0;
    int         m_cnt = 0;
    logic [1:0] m_mode = 2'b00;
    bit         last_bit = 1'b0;
    int         exp_fg = 0;

    logic [8:0] win_tab [8] = '{9'h1FE, 9'h001, 9'h1EF, 9'h1FD, 9'h1FF, 9'h000, 9'h010, 9'h1BF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // w[0]=p11 .. w[8]=p33, row-major.
    function automatic bit model_bit(input logic [8:0] w, input logic [1:0] md,
                                     input logic ben, input int x, input int y);
        bit r;
        bit on_edge;
        case (md)
            2'b00:   r = w[4];
            2'b01:   r = &w;
            2'b10:   r = |w;
            default: r = w[1] & w[3] & w[4] & w[5] & w[7];
        endcase
        on_edge = (x == 0) || (x == HI - 1) || (y == 0) || (y == VI - 1);
        return r && !(ben && on_edge);
    endfunction

    // Reference: record what each sampled input cycle must produce two cycles later.
    always @(posedge sys_clk) begin
        logic [8:0] w;
        int i;
        bit vs, valid;
        cyc++;
        i = cyc & M;
        if (!sys_rst_n) begin
            h_vs[i] = 0; h_hr[i] = 0; h_ck[i] = 0; h_bit[i] = 0; h_pulse[i] = 0; h_cnt[i] = 0;
            m_seen = 0; m_cnt = 0; m_mode = 2'b00; m_prev_vs = 0;
        end else begin
            w = {bus.matrix_p33, bus.matrix_p32, bus.matrix_p31,
                 bus.matrix_p23, bus.matrix_p22, bus.matrix_p21,
                 bus.matrix_p13, bus.matrix_p12, bus.matrix_p11};
            vs    = bus.matrix_frame_vsync;
            valid = bus.matrix_frame_href && bus.matrix_frame_clken;
            h_vs[i] = vs;
            h_hr[i] = bus.matrix_frame_href;
            h_ck[i] = bus.matrix_frame_clken;
            h_bit[i] = valid ? model_bit(w, m_mode, border_en, cur_x, cur_y) : 1'b0;
            h_pulse[i] = 0;
            h_cnt[i] = 0;
            if (vs && !m_prev_vs) begin
                h_pulse[i] = m_seen;
                h_cnt[i]   = m_cnt;
                m_cnt  = 0;
                m_seen = 1;
                m_mode = mode;
            end else if (valid && h_bit[i]) begin
                m_cnt++;
            end
            m_prev_vs = vs;
        end
    end

    always @(negedge sys_clk) begin
        int p, q;
        bit eb;
        if (!sys_rst_n) begin
            last_bit = 0;
            exp_fg   = 0;
        end else if (cyc >= 3) begin
            p = (cyc - 1) & M;
            q = (cyc - 2) & M;
            chk("post_vsync", bus.post_frame_vsync, h_vs[p]);
            chk("post_href",  bus.post_frame_href,  h_hr[p]);
            chk("post_clken", bus.post_frame_clken, h_ck[p]);
            if (!h_hr[p])     eb = 0;
            else if (h_ck[p]) eb = h_bit[p];
            else              eb = last_bit;
            last_bit = eb;
            chk("post_bit", bus.post_img_Bit, eb);
            if (h_pulse[q]) exp_fg = h_cnt[q];
            chk("fg_valid", fg_count_valid, h_pulse[q]);
            chk("fg_count", fg_count, exp_fg);
        end
        if (fg_count_valid === 1'b1) pulse_cnt++;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_win(input logic [8:0] w);
        bus.matrix_p11 = w[0]; bus.matrix_p12 = w[1]; bus.matrix_p13 = w[2];
        bus.matrix_p21 = w[3]; bus.matrix_p22 = w[4]; bus.matrix_p23 = w[5];
        bus.matrix_p31 = w[6]; bus.matrix_p32 = w[7]; bus.matrix_p33 = w[8];
    endtask

    task automatic idle();
        bus.matrix_frame_vsync = 0;
        bus.matrix_frame_href  = 0;
        bus.matrix_frame_clken = 0;
        set_win(9'h000);
    endtask

    function automatic logic [8:0] gen(input int kind, input int n);
        case (kind)
            0:       return 9'h1FF;
            1:       return 9'($urandom);
            2:       return 9'($urandom | $urandom | $urandom);
            3:       return 9'($urandom & $urandom & $urandom);
            default: return win_tab[n % 8];
        endcase
    endfunction

    task automatic drive_frame(input int kind, input bit gaps, input int chg_at,
                               input logic [1:0] new_mode, input int abort_at);
        int n = 0;
        int g;
        idle();
        bus.matrix_frame_vsync = 1;
        repeat (3) step();
        bus.matrix_frame_vsync = 0;
        repeat (2) step();
        for (int y = 0; y < VI; y++) begin
            cur_y = y;
            bus.matrix_frame_href = 1;
            for (int x = 0; x < HI; x++) begin
                cur_x = x;
                g = gaps ? $urandom_range(0, 2) : 0;
                repeat (g) begin
                    bus.matrix_frame_clken = 0;
                    set_win(9'($urandom));
                    step();
                end
                bus.matrix_frame_clken = 1;
                set_win(gen(kind, n));
                step();
                if (n == chg_at) mode = new_mode;
                n++;
                if (n == abort_at) return;
            end
            bus.matrix_frame_clken = 0;
            bus.matrix_frame_href  = 0;
            repeat (3) step();
        end
    endtask

    initial begin
        int base;
        idle();
        sys_rst_n = 0;
        repeat (3) step();
        chk("rst_post_vsync", bus.post_frame_vsync, 0);
        chk("rst_post_href",  bus.post_frame_href,  0);
        chk("rst_post_clken", bus.post_frame_clken, 0);
        chk("rst_post_bit",   bus.post_img_Bit,     0);
        chk("rst_fg_count",   fg_count,             0);
        chk("rst_fg_valid",   fg_count_valid,       0);
        sys_rst_n = 1;
        step();

        chk("model_erode_one_zero", model_bit(9'h1FE, 2'b01, 1'b0, 3, 1), 0);
        chk("model_dilate_p11",     model_bit(9'h001, 2'b10, 1'b0, 3, 1), 1);
        chk("model_cross_p11_zero", model_bit(9'h1FE, 2'b11, 1'b0, 3, 1), 1);
        chk("model_border_mask",    model_bit(9'h1FF, 2'b00, 1'b1, 0, 1), 0);

        mode = 2'b00; border_en = 0;
        drive_frame(0, 0, -1, 2'b00, -1);
        chk("first_vsync_no_pulse", pulse_cnt, 0);
        border_en = 1;
        drive_frame(0, 0, -1, 2'b00, -1);
        chk("all_ones_count", fg_count, 32);
        chk("one_pulse", pulse_cnt, 1);
        border_en = 0;
        drive_frame(1, 1, -1, 2'b00, -1);
        chk("border_count", fg_count, 12);

        drive_frame(1, 1, 10, 2'b10, -1);
        border_en = 1;
        drive_frame(3, 1, -1, 2'b00, -1);
        mode = 2'b01; border_en = 0;
        drive_frame(2, 1, -1, 2'b00, -1);
        mode = 2'b11; border_en = 1;
        drive_frame(2, 0, -1, 2'b00, -1);
        border_en = 0;
        mode = 2'b01; drive_frame(4, 0, -1, 2'b00, -1);
        mode = 2'b10; drive_frame(4, 1, -1, 2'b00, -1);
        mode = 2'b11; drive_frame(4, 0, -1, 2'b00, -1);
        for (int k = 0; k < 4; k++) begin
            mode = 2'($urandom);
            border_en = 1'($urandom);
            drive_frame($urandom_range(1, 3), 1'($urandom), -1, 2'b00, -1);
        end

        mode = 2'b00; border_en = 0;
        drive_frame(1, 0, -1, 2'b00, 13);
        #2;
        sys_rst_n = 0;
        #1;
        chk("async_post_vsync", bus.post_frame_vsync, 0);
        chk("async_post_href",  bus.post_frame_href,  0);
        chk("async_post_clken", bus.post_frame_clken, 0);
        chk("async_post_bit",   bus.post_img_Bit,     0);
        chk("async_fg_count",   fg_count,             0);
        chk("async_fg_valid",   fg_count_valid,       0);
        idle();
        repeat (3) step();
        sys_rst_n = 1;
        base = pulse_cnt;
        repeat (4) step();
        drive_frame(0, 0, -1, 2'b00, -1);
        chk("post_reset_no_pulse", pulse_cnt - base, 0);
        chk("post_reset_count",    fg_count, 0);
        drive_frame(0, 1, -1, 2'b00, -1);
        chk("post_reset_frame", fg_count, 32);

        idle();
        bus.matrix_frame_vsync = 1;
        repeat (3) step();
        idle();
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
